// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It does one bit per cycle: shift-add
// multiply or restoring divide on operand magnitudes. The sign is corrected in
// a single FIX cycle. Divide-by-zero and signed overflow complete directly.
//
// state | meaning
// IDLE  | waiting for an M-extension request (in_ready=1)
// CALC  | WIDTH iterations of shift-add / restoring divide
// FIX   | sign correction and output selection
// DONE  | result presented until out_ready
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             is_muldiv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  logic               accept;
  logic               a_signed, b_signed, a_neg, b_neg, neg_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               fast_dbz, fast_ovf;
  logic [WIDTH-1:0]   fast_val;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   fix_val;

  assign is_muldiv   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

  // A flush in the same cycle wins over a request.
  assign accept = in_valid & in_ready & is_muldiv & ~flush;

  // Operand sign handling and fast-path detection on the incoming request.
  always_comb begin
    a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
               (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    a_neg    = a_signed & SrcA[WIDTH-1];
    b_neg    = b_signed & SrcB[WIDTH-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    // The remainder takes the dividend's sign. Every other result takes the XOR of both signs.
    neg_d    = (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);
    fast_dbz = Funct3[2] && (SrcB == '0);
    fast_ovf = Funct3[2] && !Funct3[0] &&
               (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    fast_val = '0;
    if (fast_dbz) fast_val = Funct3[1] ? SrcA : '1;
    else if (fast_ovf) fast_val = Funct3[1] ? '0 : SrcA;
  end

  // One iteration step of the multiplier and the divider, plus FIX-cycle correction.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_q};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -acc_q : acc_q;
    div_sel  = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    fix_val  = '0;
    if (op_q[2]) fix_val = neg_q ? -div_sel : div_sel;
    else if (op_q == 3'b000) fix_val = prod_fix[WIDTH-1:0];
    else fix_val = prod_fix[2*WIDTH-1:WIDTH];
  end

  // Next-state logic. A flush always returns the unit to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (fast_dbz || fast_ovf) ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: operand latch, iteration accumulator, result and flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (flush) begin
      dbz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= Funct3;
          neg_q <= neg_d;
          b_q   <= b_mag;
          acc_q <= {{WIDTH{1'b0}}, a_mag};
          cnt_q <= CW'(WIDTH);
          dbz_q <= fast_dbz;
          if (fast_dbz || fast_ovf) result_q <= fast_val;
        end
        CALC: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX:  result_q <= fix_val;
        DONE: if (out_ready) dbz_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues the expected responses,
// and a negedge monitor checks result, div_by_zero, latency and stall stability.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB;
  logic         in_valid, in_ready, flush, is_muldiv;
  logic         out_valid, out_ready, div_by_zero, busy;
  logic [W-1:0] result;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .is_muldiv(is_muldiv), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .div_by_zero(div_by_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           ncyc = 0;
  int           acc_n = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] held_res;
  logic         held_dbz;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: records the accept, then checks each presented result against the queue.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (reset && in_valid && in_ready && is_muldiv && !flush) acc_n = ncyc;
    if (reset && out_valid) begin
      if (!prev_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h expected none", result);
        end else begin
          chk({sbq[0].name, "_latency"}, W'(ncyc - acc_n), W'(sbq[0].lat));
        end
        held_res = result;
        held_dbz = div_by_zero;
      end else begin
        chk("stall_result", result, held_res);
        chk("stall_dbz", W'(div_by_zero), W'(held_dbz));
        chk("stall_in_ready", W'(in_ready), W'(0));
      end
      if (out_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
      end
      prev_valid = !out_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic drive_req(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp  = 2'b10;
    Funct7 = 7'b0000001;
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ed,
                       input int el);
    exp_t e;
    int t;
    e.res = er; e.dbz = ed; e.lat = el; e.name = name;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    sbq.push_back(e);
    drive_req(f3, a, b);
    t = 0;
    while (sbq.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no result expected one within 100 cycles", name);
      sbq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b0; ALUOp = '0; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_dbz", W'(div_by_zero), W'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Combinational decode
    ALUOp = 2'b00; Funct7 = 7'b0000001; #1;
    chk("dec_aluop00", W'(is_muldiv), W'(0));
    ALUOp = 2'b10; #1;
    chk("dec_m", W'(is_muldiv), W'(1));
    @(posedge clk); #1;

    issue("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34);
    issue("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
    issue("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34);
    issue("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 34);
    issue("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34);
    issue("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34);
    issue("div_negb", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34);
    issue("rem_negb", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 34);
    issue("divu",     3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 34);
    issue("remu",     3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 34);
    issue("divu_dz",  3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1, 1);
    issue("remu_dz",  3'b111, 32'h1234,     32'd0,        32'h1234,     1'b1, 1);
    issue("div_dz",   3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, 1);
    issue("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    issue("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);

    // Non-M request is ignored
    ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("nonm_is_muldiv", W'(is_muldiv), W'(0));
      chk("nonm_busy", W'(busy), W'(0));
    end
    in_valid = 1'b0;

    // Flush mid-DIVU, then a flush together with a request in IDLE
    drive_req(3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_out_valid", W'(out_valid), W'(0));
    repeat (30) @(posedge clk);
    #1;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", W'(busy), W'(0));
    issue("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 34);

    // Back-pressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    fork
      issue("mulhu_stall", 3'b011, 32'h00010000, 32'h00030000, 32'h00000003, 1'b0, 34);
      begin
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join

    // Asynchronous reset in the middle of CALC
    drive_req(3'b101, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_result", result, '0);
    chk("arst_dbz", W'(div_by_zero), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    issue("divu_after_rst", 3'b101, 32'd1000, 32'd3, 32'd333, 1'b0, 34);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, that sits beside the single-cycle ALU in the execute stage. It decodes the same `ALUOp`/`Funct7`/`Funct3` fields the ALU control path uses and claims only M-extension encodings (`ALUOp`=10, `Funct7`=0000001). It runs a one-bit-per-cycle shift-add multiply or restoring divide, and uses valid/ready handshakes so the pipeline can stall on it. Divide-by-zero and signed overflow follow the RISC-V M rules and complete on a fast path.

## Interface
- `WIDTH`, default 32: operand and result width; must be even and ≥ 4.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ALUOp` in 2: operation class from the Controller.
- `Funct7` in 7: instruction bits 31:25.
- `Funct3` in 3: instruction bits 14:12. Selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU for 000–111.
- `SrcA`, `SrcB` in WIDTH each: rs1 and rs2 operands.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `flush` in 1: synchronous abort.
- `is_muldiv` out 1: combinational decode. High when `ALUOp`==10 and `Funct7`==0000001.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: product (low or high half), quotient or remainder.
- `div_by_zero` out 1: qualified by `out_valid`. High when a DIV/DIVU/REM/REMU request had `SrcB`==0.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, CALC, FIX, DONE.
- **Accept:** a request is accepted when `in_valid & in_ready & is_muldiv` are all high. `in_ready` = (state==IDLE).
  - `in_valid` with `is_muldiv` low is ignored. There is no state change.
  - On accept, the unit latches `Funct3`, both operands and the sign flags.
- **Operand signs:**
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
  - MUL uses the low half, which is sign-agnostic.
- **Magnitudes:** signed operands are converted to magnitude on accept. The computation is unsigned on magnitudes. The 2·WIDTH-bit product or the quotient/remainder is negated in FIX when needed.
- **Quotient sign:** negative when the operand signs differ.
- **Remainder sign:** follows the dividend.
- **Fast path:** checked on accept, and skips CALC and FIX.
  - Divide by zero: quotient = all ones; remainder = `SrcA`; `div_by_zero`=1.
  - Signed overflow (DIV/REM with A = most-negative and B = all ones): quotient = A; remainder = 0.
  - The next state is DONE.
- **CALC:** processes one bit per cycle for exactly WIDTH cycles. A counter of width $clog2(WIDTH+1) counts down from WIDTH. It moves to FIX when the counter reaches 1.
- **FIX:** applies sign correction and selects the output half. It moves to DONE.
- **DONE:** `out_valid`=1 and `result` is held stable. It moves to IDLE on `out_ready`.
- **Flush:** `flush` in any state returns the unit to IDLE on the next edge and clears `out_valid` and `div_by_zero`.
  - `flush` has priority over `in_valid` in the same cycle. Nothing is accepted.
- **Reset:** asynchronous reset at any point, including mid-CALC, forces the following immediately, independent of `clk`:
  - state = IDLE
  - `out_valid`=0, `result`=0, `div_by_zero`=0, `busy`=0
  - `in_ready`=1 once `reset` is released.

## Timing
- The accept edge is cycle 0.
- **Normal path:** CALC occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, and `out_valid` rises at cycle WIDTH+2. That is 34 cycles for WIDTH=32.
- **Fast path:** `out_valid` rises at cycle 1.
- **Back-pressure:** `out_valid` holds while `out_ready`=0. `result` and `div_by_zero` must not change during this time.
- **Throughput:** when `out_ready` is high in DONE, the unit is in IDLE next cycle. The earliest following accept is one cycle after the handover.
- `is_muldiv` is purely combinational from `ALUOp`/`Funct7`. It is valid in every state.
- `in_ready` and `busy` are registered-state decodes, with no combinational path from `in_valid`.

## Test plan
- **MUL** (Funct3=000), A=7, B=0xFFFFFFFD → result 0xFFFFFFEB at cycle 34; `div_by_zero`=0.
- **MULHU** (011), A=B=0xFFFFFFFF → 0xFFFFFFFE.
- **MULH** (001), A=0x80000000, B=0x80000000 → 0x40000000.
- **DIV** (100), A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD.
- **REM** (110), same operands → 0xFFFFFFFF.
- **DIVU by zero** (101), A=0x1234, B=0 → 0xFFFFFFFF with `div_by_zero`=1 at cycle 1.
- **REMU by zero** (111), A=0x1234, B=0 → 0x1234.
- **DIV overflow** (100), A=0x80000000, B=0xFFFFFFFF → 0x80000000 at cycle 1.
- **REM overflow** (110), same operands → 0.
- **Non-M request:** `ALUOp`=10, `Funct7`=0000000, `in_valid`=1 → `is_muldiv`=0, not accepted, `busy` stays 0.
- **Flush and stall:**
  - Assert `flush` at cycle 10 of a DIVU → IDLE at cycle 11, `out_valid` never asserts. A new MUL 3×5 accepted afterwards returns 15.
  - Hold `out_ready`=0 for 5 cycles in DONE → `result` stable and `in_ready`=0 throughout.
- **Reset mid-CALC:** drop `reset` at cycle 12 → all outputs immediately take their reset values. After release, `in_ready`=1 and a fresh request completes correctly.
